chargen_blit_ctrl: RTL and testbench

- Sits between the Wishbone slave and the chargen screen-memory read/write port.
- Arbitrates that port between CPU accesses and an internal blit engine.
- The engine executes FILL (constant word over a range) and COPY (overlap-safe memmove, used for scrolling) on the 2048 x 32-bit screen memory. Each word holds char0/attr0/char1/attr1.
- CPU accesses always have priority; the engine proceeds only in idle bus cycles.

---
 rtl/chargen_blit_ctrl_if.sv | 43 ++++
 rtl/chargen_blit_ctrl.sv | 163 ++++++++++++++++
 tb/tb_chargen_blit_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chargen_blit_ctrl_if.sv
// Bus bundle for chargen_blit_ctrl: Wishbone slave side, blit command port
// and the chargen screen-memory read/write port.
interface chargen_blit_ctrl_if #(
  parameter int AW = 11,
  parameter int LW = 12
);
  logic [AW-1:0] ADR_I;
  logic [31:0]   DAT_I;
  logic [31:0]   DAT_O;
  logic          WE_I;
  logic [3:0]    SEL_I;
  logic          STB_I;
  logic          CYC_I;
  logic          ACK_O;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;
  logic [31:0]   cmd_fill;
  logic          cmd_abort;

  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_we;
  logic [31:0]   mem_rdata;

  modport slave (
    input  ADR_I, DAT_I, WE_I, SEL_I, STB_I, CYC_I,
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_abort,
    input  mem_rdata,
    output DAT_O, ACK_O, cmd_ready, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output ADR_I, DAT_I, WE_I, SEL_I, STB_I, CYC_I,
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_abort,
    output mem_rdata,
    input  DAT_O, ACK_O, cmd_ready, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/chargen_blit_ctrl.sv
// Screen-memory port arbiter with FILL/COPY blit engine; CPU always wins the port.
// Optional frame-sync gating of command start: define CHARGEN_BLIT_VSYNC_GATE_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | ready for a command
// S_WAIT_VS | command held until framesync rising edge (optional build)
// S_FILL    | one constant-word write per granted cycle
// S_C_RD    | present copy source address
// S_C_LAT   | capture read data into hold
// S_C_WR    | write hold to destination, step pointers
// S_DONE    | one-cycle completion pulse
module chargen_blit_ctrl #(
  parameter int AW = 11,
  parameter int LW = 12
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  input  logic         framesync,
  output logic         busy,
  output logic         done,
  chargen_blit_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_C_RD,
    S_C_LAT,
    S_C_WR,
    S_DONE
`ifdef CHARGEN_BLIT_VSYNC_GATE_EN
    , S_WAIT_VS
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] src_ptr, dst_ptr;
  logic [LW-1:0] len_cnt;
  logic [31:0]   fill_val, hold;
  logic          desc;
  logic          waitstate, ack_q;
  logic          cpu_req, gnt, accept, last_word, start_desc;
  logic [AW-1:0] cmd_diff;

  assign cpu_req   = bus.CYC_I & bus.STB_I;
  assign gnt       = ~cpu_req;
  assign accept    = (state == S_IDLE) & bus.cmd_valid;
  assign last_word = (len_cnt == LW'(1));

  // Destination inside the source window means an ascending copy would clobber unread words.
  assign cmd_diff   = bus.cmd_dst - bus.cmd_src;
  assign start_desc = bus.cmd_op & (cmd_diff != '0) & (LW'(cmd_diff) < bus.cmd_len);

`ifdef CHARGEN_BLIT_VSYNC_GATE_EN
  logic fs_q, fs_prev, fs_rise, op_copy;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      fs_q    <= 1'b0;
      fs_prev <= 1'b0;
      op_copy <= 1'b0;
    end else begin
      fs_q    <= framesync;
      fs_prev <= fs_q;
      if (accept) op_copy <= bus.cmd_op;
    end
  end

  assign fs_rise = fs_q & ~fs_prev;
`else
  logic unused_framesync;
  assign unused_framesync = framesync;
`endif

  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0)
            state_nxt = S_DONE;
          else
`ifdef CHARGEN_BLIT_VSYNC_GATE_EN
            state_nxt = S_WAIT_VS;
`else
            state_nxt = bus.cmd_op ? S_C_RD : S_FILL;
`endif
        end
      end
`ifdef CHARGEN_BLIT_VSYNC_GATE_EN
      S_WAIT_VS: if (fs_rise) state_nxt = op_copy ? S_C_RD : S_FILL;
`endif
      S_FILL:  if (gnt && last_word) state_nxt = S_DONE;
      S_C_RD:  if (gnt) state_nxt = S_C_LAT;
      S_C_LAT: state_nxt = S_C_WR;
      S_C_WR:  if (gnt) state_nxt = last_word ? S_DONE : S_C_RD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.cmd_abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      src_ptr  <= '0;
      dst_ptr  <= '0;
      len_cnt  <= '0;
      fill_val <= '0;
      desc     <= 1'b0;
      hold     <= '0;
    end else begin
      if (accept) begin
        desc     <= start_desc;
        fill_val <= bus.cmd_fill;
        len_cnt  <= bus.cmd_len;
        src_ptr  <= start_desc ? bus.cmd_src + bus.cmd_len[AW-1:0] - AW'(1) : bus.cmd_src;
        dst_ptr  <= start_desc ? bus.cmd_dst + bus.cmd_len[AW-1:0] - AW'(1) : bus.cmd_dst;
      end
      // Read data belongs to the address issued in the preceding granted C_RD cycle.
      if (state == S_C_LAT) hold <= bus.mem_rdata;
      if (gnt && ((state == S_FILL) || (state == S_C_WR))) begin
        len_cnt <= len_cnt - LW'(1);
        dst_ptr <= desc ? dst_ptr - AW'(1) : dst_ptr + AW'(1);
        if (state == S_C_WR) src_ptr <= desc ? src_ptr - AW'(1) : src_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      waitstate <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      waitstate <= cpu_req & ~bus.WE_I & ~waitstate;
      ack_q     <= cpu_req & (bus.WE_I | waitstate);
    end
  end

  assign bus.ACK_O = ack_q;
  assign bus.DAT_O = bus.mem_rdata;

  always_comb begin
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    bus.cmd_ready = (state == S_IDLE);
    if (cpu_req) begin
      bus.mem_addr  = bus.ADR_I;
      bus.mem_wdata = bus.DAT_I;
      bus.mem_we    = bus.SEL_I & {4{bus.WE_I}};
    end else begin
      bus.mem_addr  = (state == S_C_RD) ? src_ptr : dst_ptr;
      bus.mem_wdata = (state == S_C_WR) ? hold : fill_val;
      bus.mem_we    = ((state == S_FILL) || (state == S_C_WR)) ? 4'hF : 4'h0;
    end
  end

endmodule

// File: tb/tb_chargen_blit_ctrl.sv
// Directed bench for chargen_blit_ctrl with a 2048 x 32 synchronous screen-memory model.
module tb_chargen_blit_ctrl;
  localparam int AW = 11;
  localparam int LW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic framesync = 1'b0;
  logic busy, done;

  chargen_blit_ctrl_if #(.AW(AW), .LW(LW)) bus ();

  chargen_blit_ctrl #(.AW(AW), .LW(LW)) dut (
    .CLK_I     (clk),
    .RST_I     (rst),
    .framesync (framesync),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  logic        pl_req = 1'b0;
  logic [1:0]  pl_kind = 2'd0;

  always @(posedge clk) begin
    if (pl_req) begin
      for (int i = 0; i < 2048; i++) begin
        case (pl_kind)
          2'd1:    mem[i] <= 32'(i);
          2'd2:    mem[i] <= 32'hC0DE_0000 | 32'(i);
          default: mem[i] <= 32'h0;
        endcase
      end
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int eng_wr = 0;
  int bad_wr = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    if ((bus.mem_we != 4'h0) && !(bus.CYC_I && bus.STB_I)) eng_wr <= eng_wr + 1;
    if ((bus.mem_we != 4'h0) && bus.CYC_I && bus.STB_I && !bus.WE_I) bad_wr <= bad_wr + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [1:0] kind);
    @(posedge clk); #1;
    pl_kind = kind;
    pl_req  = 1'b1;
    @(posedge clk); #1;
    pl_req  = 1'b0;
  endtask

  task automatic cpu_idle();
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
  endtask

  task automatic cpu_xfer(input logic we, input logic [10:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = we;
    bus.ADR_I = adr;  bus.DAT_I = dat;  bus.SEL_I = sel;
    lat = -1;
    rd  = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.ACK_O) begin
        lat = k;
        rd  = bus.DAT_O;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_idle();
  endtask

  task automatic issue_cmd(input logic op, input logic [10:0] src, input logic [10:0] dst,
                           input logic [11:0] len, input logic [31:0] fill);
    @(posedge clk); #1;
    bus.cmd_op = op; bus.cmd_src = src; bus.cmd_dst = dst;
    bus.cmd_len = len; bus.cmd_fill = fill; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic op, input logic [10:0] src, input logic [10:0] dst,
                         input logic [11:0] len, input logic [31:0] fill, input int maxc,
                         output int lat, output int busy_low);
    issue_cmd(op, src, dst, len, fill);
    lat = -1;
    busy_low = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [10:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } cpu_vec_t;

  cpu_vec_t cv [5];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat, blow, w0, b0, d0, bad, done_c;

    cv[0] = '{11'h300, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    cv[1] = '{11'h301, 4'h1, 32'h1234_5678, 32'h0000_0078};
    cv[2] = '{11'h302, 4'h6, 32'hAABB_CCDD, 32'h00BB_CC00};
    cv[3] = '{11'h303, 4'h8, 32'h1234_5678, 32'h1200_0000};
    cv[4] = '{11'h300, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF};

    cpu_idle();
    bus.ADR_I = '0; bus.DAT_I = '0; bus.SEL_I = 4'h0;
    bus.cmd_valid = 1'b0; bus.cmd_abort = 1'b0; bus.cmd_op = 1'b0;
    bus.cmd_src = '0; bus.cmd_dst = '0; bus.cmd_len = '0; bus.cmd_fill = '0;

    rst = 1'b1;
    preload(2'd0);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack", 32'(bus.ACK_O), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // CPU byte-lane writes and read-back latency
    for (int i = 0; i < 5; i++) begin
      cpu_xfer(1'b1, cv[i].adr, cv[i].wdata, cv[i].sel, rd, lat);
      check($sformatf("cpu_wr_lat[%0d]", i), 32'(lat), 32'd1);
      cpu_xfer(1'b0, cv[i].adr, 32'h0, 4'hF, rd, lat);
      check($sformatf("cpu_rd_lat[%0d]", i), 32'(lat), 32'd2);
      check($sformatf("cpu_rd_data[%0d]", i), rd, cv[i].rexp);
    end

    w0 = eng_wr; d0 = done_cnt;
    run_cmd(1'b0, 11'h0, 11'h123, 12'd0, 32'hFFFF_FFFF, 10, lat, blow);
    check("len0_lat", 32'(lat), 32'd1);
    check("len0_writes", 32'(eng_wr - w0), 32'd0);
    check("len0_done", 32'(done_cnt - d0), 32'd1);

`ifndef CHARGEN_BLIT_VSYNC_GATE_EN
    // FILL across the 0x7FF -> 0x000 wrap
    preload(2'd0);
    run_cmd(1'b0, 11'h0, 11'h7F0, 12'd32, 32'h0720_0720, 60, lat, blow);
    check("fill_lat", 32'(lat), 32'd33);
    check("fill_busy_low", 32'(blow), 32'd0);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (mem[(11'h7F0 + 11'(i))] !== 32'h0720_0720) bad++;
    check("fill_words", 32'(bad), 32'd0);
    check("fill_after", mem[11'h010], 32'h0);
    check("fill_before", mem[11'h7EF], 32'h0);
    cpu_xfer(1'b0, 11'h7F0, 32'h0, 4'hF, rd, lat);
    check("fill_cpu_rd_7f0", rd, 32'h0720_0720);
    cpu_xfer(1'b0, 11'h00F, 32'h0, 4'hF, rd, lat);
    check("fill_cpu_rd_00f", rd, 32'h0720_0720);

    // scroll up: dst-src = 1984 is not < len, so ascending
    preload(2'd1);
    run_cmd(1'b1, 11'd64, 11'd0, 12'd1984, 32'h0, 7000, lat, blow);
    check("scroll_lat", 32'(lat), 32'd5953);
    bad = 0;
    for (int i = 0; i < 2048; i++)
      if (mem[i] !== ((i < 1984) ? 32'(i + 64) : 32'(i))) bad++;
    check("scroll_data", 32'(bad), 32'd0);

    // overlapping copy forces descending order
    preload(2'd2);
    run_cmd(1'b1, 11'd0, 11'd1, 12'd4, 32'h0, 40, lat, blow);
    check("ovl_lat", 32'(lat), 32'd13);
    check("ovl_w0", mem[0], 32'hC0DE_0000);
    check("ovl_w1", mem[1], 32'hC0DE_0000);
    check("ovl_w2", mem[2], 32'hC0DE_0001);
    check("ovl_w3", mem[3], 32'hC0DE_0002);
    check("ovl_w4", mem[4], 32'hC0DE_0003);

    // CPU read burst from C_LAT (6 stolen cycles) and a write during C_RD (2 stolen)
    preload(2'd2);
    w0 = eng_wr; b0 = bad_wr;
    issue_cmd(1'b1, 11'h400, 11'h500, 12'd4, 32'h0);
    done_c = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c >= 5 && c <= 11) begin
        bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b0; bus.SEL_I = 4'hF;
        bus.ADR_I = (c <= 7) ? 11'h010 : ((c <= 9) ? 11'h011 : 11'h012);
      end else if (c == 13 || c == 14) begin
        bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b1; bus.SEL_I = 4'hF;
        bus.ADR_I = 11'h020; bus.DAT_I = 32'h5A5A_5A5A;
      end else begin
        cpu_idle();
      end
      @(negedge clk);
      if (c == 7 || c == 9 || c == 11) begin
        check($sformatf("cont_rd_ack_c%0d", c), 32'(bus.ACK_O), 32'd1);
        check($sformatf("cont_rd_data_c%0d", c), bus.DAT_O,
              32'hC0DE_0010 + 32'((c - 7) / 2));
      end
      if (c == 14) check("cont_wr_ack", 32'(bus.ACK_O), 32'd1);
      if (done && done_c < 0) done_c = c;
      @(posedge clk); #1;
    end
    check("cont_done_lat", 32'(done_c), 32'd21);
    check("cont_eng_writes", 32'(eng_wr - w0), 32'd4);
    check("cont_wr_in_cpu_rd", 32'(bad_wr - b0), 32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (mem[11'h500 + 11'(i)] !== (32'hC0DE_0400 + 32'(i))) bad++;
    check("cont_copy_data", 32'(bad), 32'd0);
    check("cont_cpu_wr_data", mem[11'h020], 32'h5A5A_5A5A);

    // abort during the 90th write of a 100-word FILL
    preload(2'd0);
    w0 = eng_wr; d0 = done_cnt;
    issue_cmd(1'b0, 11'h0, 11'h100, 12'd100, 32'h1234_ABCD);
    repeat (89) @(posedge clk);
    #1;
    bus.cmd_abort = 1'b1;
    @(posedge clk); #1;
    bus.cmd_abort = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("abort_writes", 32'(eng_wr - w0), 32'd90);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_last_word", mem[11'h100 + 11'd89], 32'h1234_ABCD);
    check("abort_next_word", mem[11'h100 + 11'd90], 32'h0);

    // synchronous reset mid-COPY with a CPU read in flight
    preload(2'd2);
    d0 = done_cnt;
    issue_cmd(1'b1, 11'h400, 11'h600, 12'd50, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b0; bus.ADR_I = 11'h010;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_idle();
    w0 = eng_wr;
    @(negedge clk);
    check("rst2_ack", 32'(bus.ACK_O), 32'd0);
    check("rst2_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_mem_we", 32'(bus.mem_we), 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst2_no_writes", 32'(eng_wr - w0), 32'd0);
    check("rst2_no_done", 32'(done_cnt - d0), 32'd0);

    run_cmd(1'b0, 11'h0, 11'h700, 12'd2, 32'h0BAD_F00D, 20, lat, blow);
    check("post_rst_fill_lat", 32'(lat), 32'd3);
    check("post_rst_fill_data", mem[11'h701], 32'h0BAD_F00D);
`else
    // command must wait for a framesync rising edge
    preload(2'd0);
    w0 = eng_wr; d0 = done_cnt;
    issue_cmd(1'b0, 11'h0, 11'h600, 12'd4, 32'hFEED_F00D);
    repeat (49) @(posedge clk);
    @(negedge clk);
    check("vs_busy_waiting", 32'(busy), 32'd1);
    check("vs_no_writes_before", 32'(eng_wr - w0), 32'd0);
    @(posedge clk); #1;
    framesync = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("vs_no_writes_at_sample", 32'(eng_wr - w0), 32'd0);
    done_c = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        done_c = c;
        break;
      end
    end
    framesync = 1'b0;
    @(posedge clk); #1;
    check("vs_done_seen", 32'(done_c >= 0), 32'd1);
    check("vs_writes", 32'(eng_wr - w0), 32'd4);
    check("vs_data", mem[11'h603], 32'hFEED_F00D);
    check("vs_done_cnt", 32'(done_cnt - d0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
